// File: rtl/store_commit_sequencer_pkg.sv
// Shared LSU definitions: store sequencer FSM state and STQ {wrap, index} tag arithmetic.
package store_commit_sequencer_pkg;

    // Widest STQ tag any LSU block may pass through stq_tag_inc.
    localparam int unsigned StqTagMaxW = 16;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StWaitAck = 2'd2
    } stq_seq_state_t;

    // Advance a tag modulo 2*stq_size; the bit above the index acts as the wrap flag.
    function automatic logic [StqTagMaxW-1:0] stq_tag_inc(input logic [StqTagMaxW-1:0] tag,
                                                          input int unsigned stq_size);
        logic [StqTagMaxW-1:0] mask;
        mask = StqTagMaxW'((stq_size << 1) - 1);
        return (tag + StqTagMaxW'(1)) & mask;
    endfunction

endpackage

// File: rtl/stq_head_pointer.sv
// STQ head tag register: wrap-aware increment, index extraction and one-hot index decode.
module stq_head_pointer
    import store_commit_sequencer_pkg::*;
#(
    parameter int unsigned STQ_SIZE      = 8,
    parameter int unsigned STQ_TAG_WIDTH = $clog2(STQ_SIZE) + 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     advance_i,
    output logic [STQ_TAG_WIDTH-1:0] head_o,
    output logic [STQ_TAG_WIDTH-2:0] head_idx_o,
    output logic [STQ_SIZE-1:0]      head_onehot_o
);

    logic [STQ_TAG_WIDTH-1:0] head_q, head_d;

    always_comb begin
        head_d = head_q;
        if (advance_i) begin
            head_d = STQ_TAG_WIDTH'(stq_tag_inc(StqTagMaxW'(head_q), STQ_SIZE));
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            head_q <= '0;
        end else begin
            head_q <= head_d;
        end
    end

    assign head_o     = head_q;
    assign head_idx_o = head_q[STQ_TAG_WIDTH-2:0];

    always_comb begin
        head_onehot_o             = '0;
        head_onehot_o[head_idx_o] = 1'b1;
    end

endmodule

// File: rtl/store_commit_sequencer.sv
// Drains committed stores from the STQ head into data memory one at a time, in order.
// Optional LSU_ORDER_FAILURE_LATCH_EN: sticky order-failure latch that stalls stores until flushed.
module store_commit_sequencer
    import store_commit_sequencer_pkg::*;
#(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned STQ_SIZE      = 8,
    parameter int unsigned STQ_TAG_WIDTH = $clog2(STQ_SIZE) + 1,
    parameter int unsigned LDQ_SIZE      = 8
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [STQ_SIZE-1:0]                stq_valid_i,
    input  logic [STQ_SIZE-1:0]                stq_committed_i,
    input  logic [STQ_SIZE-1:0]                stq_address_valid_i,
    input  logic [STQ_SIZE-1:0]                stq_data_valid_i,
    input  logic [STQ_SIZE-1:0][XLEN-1:0]      stq_address_i,
    input  logic [STQ_SIZE-1:0][XLEN-1:0]      stq_data_i,
    output logic                               mem_req_valid_o,
    input  logic                               mem_req_ready_i,
    output logic [XLEN-1:0]                    mem_req_addr_o,
    output logic [XLEN-1:0]                    mem_req_data_o,
    input  logic                               mem_resp_valid_i,
    output logic [STQ_TAG_WIDTH-1:0]           stq_head_o,
    output logic [STQ_SIZE-1:0]                stq_dequeue_o,
    output logic                               store_fired_o,
    output logic [STQ_TAG_WIDTH-1:0]           store_fired_tag_o,
    input  logic [LDQ_SIZE-1:0]                order_failures_i,
    output logic                               order_flush_o,
    input  logic                               order_flush_ack_i
);

    stq_seq_state_t           state_q, state_d;
    logic [XLEN-1:0]          addr_q, addr_d;
    logic [XLEN-1:0]          data_q, data_d;
    logic [STQ_TAG_WIDTH-1:0] head;
    logic [STQ_TAG_WIDTH-2:0] head_idx;
    logic [STQ_SIZE-1:0]      head_onehot;
    logic                     head_eligible;
    logic                     fire;
    logic                     flush_block;

    stq_head_pointer #(
        .STQ_SIZE      (STQ_SIZE),
        .STQ_TAG_WIDTH (STQ_TAG_WIDTH)
    ) u_head (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .advance_i     (fire),
        .head_o        (head),
        .head_idx_o    (head_idx),
        .head_onehot_o (head_onehot)
    );

    assign head_eligible = stq_valid_i[head_idx] & stq_committed_i[head_idx] &
                           stq_address_valid_i[head_idx] & stq_data_valid_i[head_idx];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        fire    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Capture the head entry now so the request stays stable while stalled.
                if (head_eligible && !flush_block) begin
                    state_d = StReq;
                    addr_d  = stq_address_i[head_idx];
                    data_d  = stq_data_i[head_idx];
                end
            end
            StReq: begin
                if (mem_req_ready_i) begin
                    state_d = StWaitAck;
                end
            end
            StWaitAck: begin
                if (mem_resp_valid_i) begin
                    state_d = StIdle;
                    fire    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign mem_req_valid_o   = (state_q == StReq);
    assign mem_req_addr_o    = addr_q;
    assign mem_req_data_o    = data_q;
    assign stq_head_o        = head;
    assign store_fired_o     = fire;
    assign store_fired_tag_o = fire ? head : '0;
    assign stq_dequeue_o     = fire ? head_onehot : '0;

`ifdef LSU_ORDER_FAILURE_LATCH_EN
    logic [LDQ_SIZE-1:0] pending_q, pending_d;

    // A failure reported in the same cycle as an ack survives the clear.
    always_comb begin
        pending_d = order_flush_ack_i ? '0 : pending_q;
        if (fire) begin
            pending_d = pending_d | order_failures_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign order_flush_o = |pending_q;
    assign flush_block   = |pending_q;
`else
    logic unused_ack;

    assign unused_ack    = order_flush_ack_i;
    assign order_flush_o = fire & (|order_failures_i);
    assign flush_block   = 1'b0;
`endif

endmodule

// File: tb/tb_store_commit_sequencer.sv
// Randomized bench for store_commit_sequencer against a transaction-level store-ordering model.
module tb_store_commit_sequencer;

    localparam int unsigned XLEN = 32;
    localparam int unsigned STQ_SIZE = 8;
    localparam int unsigned TAGW = 4;
    localparam int unsigned LDQ_SIZE = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [STQ_SIZE-1:0] b_v, b_c, b_av, b_dv;
    logic [STQ_SIZE-1:0][XLEN-1:0] b_addr, b_data;
    logic mem_req_valid, mem_req_ready, mem_resp_valid;
    logic [XLEN-1:0] mem_req_addr, mem_req_data;
    logic [TAGW-1:0] stq_head, store_fired_tag;
    logic [STQ_SIZE-1:0] stq_dequeue;
    logic store_fired, order_flush, order_flush_ack;
    logic [LDQ_SIZE-1:0] order_failures;

    always #5 clk = ~clk;

    store_commit_sequencer #(
        .XLEN(XLEN), .STQ_SIZE(STQ_SIZE), .STQ_TAG_WIDTH(TAGW), .LDQ_SIZE(LDQ_SIZE)
    ) dut (
        .clk_i               (clk),
        .reset_i             (reset),
        .stq_valid_i         (b_v),
        .stq_committed_i     (b_c),
        .stq_address_valid_i (b_av),
        .stq_data_valid_i    (b_dv),
        .stq_address_i       (b_addr),
        .stq_data_i          (b_data),
        .mem_req_valid_o     (mem_req_valid),
        .mem_req_ready_i     (mem_req_ready),
        .mem_req_addr_o      (mem_req_addr),
        .mem_req_data_o      (mem_req_data),
        .mem_resp_valid_i    (mem_resp_valid),
        .stq_head_o          (stq_head),
        .stq_dequeue_o       (stq_dequeue),
        .store_fired_o       (store_fired),
        .store_fired_tag_o   (store_fired_tag),
        .order_failures_i    (order_failures),
        .order_flush_o       (order_flush),
        .order_flush_ack_i   (order_flush_ack)
    );

    int n_total = 0;
    int n_bad = 0;

    // Model: expected head tag, outstanding-store phase (0 none, 1 requested, 2 accepted),
    // cycles until the memory answers, and whether a request is due next cycle.
    int m_head, m_out, m_cnt, cyc, tail, free_idx;
    bit m_pred, free_pending, stale_resp, saw_tag8;
    logic [LDQ_SIZE-1:0] m_pend;
    int first_req_cyc, first_fire_cyc, n_req_cycles;
    logic obs_valid, obs_flush;
    logic [TAGW-1:0] obs_head;

    int k_ready, k_lat_min, k_lat_max, k_alloc, k_bit, k_stray, k_fail, k_ack, k_fail_fixed;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_state();
        b_v = '0; b_c = '0; b_av = '0; b_dv = '0;
        b_addr = '0; b_data = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        order_failures = '0; order_flush_ack = 1'b0;
        m_head = 0; m_out = 0; m_cnt = 0; m_pred = 1'b0; m_pend = '0;
        tail = 0; free_pending = 1'b0; cyc = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_head"}, stq_head, 0);
        check_eq({tag, "_req_valid"}, mem_req_valid, 0);
        check_eq({tag, "_addr"}, mem_req_addr, 0);
        check_eq({tag, "_data"}, mem_req_data, 0);
        check_eq({tag, "_dequeue"}, stq_dequeue, 0);
        check_eq({tag, "_fired"}, store_fired, 0);
        check_eq({tag, "_fired_tag"}, store_fired_tag, 0);
        check_eq({tag, "_flush"}, order_flush, 0);
    endtask

    // Entered just after a rising edge; leaves just after a later rising edge.
    task automatic do_reset(input int n, input bit stale);
        reset = 1'b1;
        #4;
        check_reset_vals("rst_async");
        for (int i = 1; i < n; i++) begin
            @(posedge clk);
            #4;
            check_reset_vals("rst_hold");
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_state();
        stale_resp = stale;
    endtask

    task automatic load_entry(input int idx, input bit dv);
        b_v[idx] = 1'b1; b_c[idx] = 1'b1; b_av[idx] = 1'b1; b_dv[idx] = dv;
        b_addr[idx] = $urandom;
        b_data[idx] = $urandom;
        tail = (idx + 1) % STQ_SIZE;
    endtask

    task automatic drive();
        if (free_pending) begin
            b_v[free_idx] = 1'b0; b_c[free_idx] = 1'b0;
            b_av[free_idx] = 1'b0; b_dv[free_idx] = 1'b0;
            free_pending = 1'b0;
        end
        mem_req_ready = ($urandom_range(99) < k_ready);
        mem_resp_valid = 1'b0;
        if (m_out == 2) begin
            if (m_cnt == 1) mem_resp_valid = 1'b1;
            if (m_cnt > 0) m_cnt--;
        end else if (stale_resp) begin
            mem_resp_valid = 1'b1;
            stale_resp = 1'b0;
        end else if ($urandom_range(99) < k_stray) begin
            mem_resp_valid = 1'b1;
        end
        if (k_fail_fixed != 0) order_failures = LDQ_SIZE'(k_fail_fixed);
        else if ($urandom_range(99) < k_fail) order_failures = LDQ_SIZE'($urandom_range(255, 1));
        else order_failures = '0;
        order_flush_ack = ($urandom_range(99) < k_ack);
        if (!b_v[tail] && $urandom_range(99) < k_alloc) begin
            b_v[tail] = 1'b1;
            b_addr[tail] = $urandom;
            b_data[tail] = $urandom;
            tail = (tail + 1) % STQ_SIZE;
        end
        for (int i = 0; i < STQ_SIZE; i++) begin
            if (b_v[i]) begin
                if ($urandom_range(99) < k_bit) b_c[i] = 1'b1;
                if ($urandom_range(99) < k_bit) b_av[i] = 1'b1;
                if ($urandom_range(99) < k_bit) b_dv[i] = 1'b1;
            end
        end
    endtask

    task automatic sample();
        bit exp_fire, exp_valid, elig, next_pred, blocked;
        int idx;
        idx = m_head % STQ_SIZE;
        exp_fire = (m_out == 2) && mem_resp_valid;
        exp_valid = (m_out == 1) || (m_out == 0 && m_pred);
        check_eq("head", stq_head, m_head);
        check_eq("req_valid", mem_req_valid, exp_valid);
        if (exp_valid) begin
            check_eq("req_addr", mem_req_addr, b_addr[idx]);
            check_eq("req_data", mem_req_data, b_data[idx]);
        end
        check_eq("fired", store_fired, exp_fire);
        check_eq("fired_tag", store_fired_tag, exp_fire ? m_head : 0);
        check_eq("dequeue", stq_dequeue, exp_fire ? (64'd1 << idx) : 64'd0);
`ifdef LSU_ORDER_FAILURE_LATCH_EN
        check_eq("flush", order_flush, |m_pend);
        blocked = (m_pend != '0);
`else
        check_eq("flush", order_flush, exp_fire && (order_failures != '0));
        blocked = 1'b0;
`endif
        obs_valid = mem_req_valid;
        obs_head = stq_head;
        obs_flush = order_flush;
        if (mem_req_valid) begin
            n_req_cycles++;
            if (first_req_cyc < 0) first_req_cyc = cyc;
        end
        if (store_fired) begin
            if (first_fire_cyc < 0) first_fire_cyc = cyc;
            if (store_fired_tag == 4'd8) saw_tag8 = 1'b1;
        end
        elig = b_v[idx] & b_c[idx] & b_av[idx] & b_dv[idx];
        next_pred = 1'b0;
        if (exp_fire) begin
            m_out = 0;
            free_pending = 1'b1;
            free_idx = idx;
            m_head = (m_head + 1) % (2 * STQ_SIZE);
        end else if (exp_valid) begin
            if (mem_req_ready) begin
                m_out = 2;
                m_cnt = $urandom_range(k_lat_max, k_lat_min);
            end else begin
                m_out = 1;
            end
        end else if (m_out == 0) begin
            next_pred = elig && !blocked;
        end
        m_pend = (order_flush_ack ? '0 : m_pend) | (exp_fire ? order_failures : '0);
        m_pred = next_pred;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive();
            #4;
            sample();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_knobs(input int ready, input int lat_min, input int lat_max,
                             input int alloc, input int bits, input int stray,
                             input int fail, input int ack);
        k_ready = ready; k_lat_min = lat_min; k_lat_max = lat_max; k_alloc = alloc;
        k_bit = bits; k_stray = stray; k_fail = fail; k_ack = ack; k_fail_fixed = 0;
    endtask

    initial begin
        bit did_reset;
        saw_tag8 = 1'b0;
        stale_resp = 1'b0;
        clear_state();
        @(posedge clk);
        #1;
        do_reset(2, 1'b0);

        // Single store, ready immediately, response two cycles after acceptance.
        set_knobs(100, 2, 2, 0, 0, 0, 0, 0);
        first_req_cyc = -1; first_fire_cyc = -1;
        load_entry(0, 1'b1);
        run(6);
        check_eq("t1_req_cycle", first_req_cyc, 1);
        check_eq("t1_fire_cycle", first_fire_cyc, 3);
        check_eq("t1_head", obs_head, 1);

        // Memory not ready for several cycles: request held, no fire.
        set_knobs(0, 1, 1, 0, 0, 0, 0, 0);
        load_entry(1, 1'b1);
        run(7);
        check_eq("t2_req_held", obs_valid, 1);
        check_eq("t2_head_held", obs_head, 1);
        k_ready = 100;
        run(5);
        check_eq("t2_head_after", obs_head, 2);

        // Data not yet valid: no request until it arrives.
        n_req_cycles = 0;
        load_entry(2, 1'b0);
        run(4);
        check_eq("t3_no_req", n_req_cycles, 0);
        b_dv[2] = 1'b1;
        run(1);
        check_eq("t3_still_idle", obs_valid, 0);
        run(1);
        check_eq("t3_req_next", obs_valid, 1);
        run(4);

        // Order failure at the fire of entry 3; entry 4 waits for the flush ack when latched.
        k_fail_fixed = 4;
        load_entry(3, 1'b1);
        load_entry(4, 1'b1);
        run(10);
`ifdef LSU_ORDER_FAILURE_LATCH_EN
        check_eq("t4_stalled_head", obs_head, 4);
        check_eq("t4_flush_held", obs_flush, 1);
`else
        check_eq("t4_nostall_head", obs_head, 5);
`endif
        k_fail_fixed = 0;
        k_ack = 100;
        run(8);
        check_eq("t4_head_after_ack", obs_head, 5);
        check_eq("t4_flush_cleared", obs_flush, 0);

        // Random traffic with a reset pulsed mid-transaction and a stale response after it.
        set_knobs(60, 1, 3, 50, 40, 10, 10, 30);
        did_reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!did_reset && i > 1500 && m_out == 2) begin
                check_eq("wrap_tag8_seen", saw_tag8, 1);
                do_reset(2, 1'b1);
                did_reset = 1'b1;
            end
            run(1);
        end
        check_eq("mid_reset_done", did_reset, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
